pc_unit: RTL and testbench
==========================

# pc_unit

Program-counter and control-flow sequencer for the 16-bit single-cycle core. It consumes the branch-taken decision produced by the flag register file, together with the current instruction, and computes the next PC each cycle. It also maintains the hardware return-address stack used by CALL and RET. Its registered `pc` output drives instruction fetch, so this block closes the loop from flag evaluation back to fetch.

## Interface
- `DEPTH`, 8: return-stack entries; must be a power of 2, ≥2.
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `stall` in 1: when 1, all state holds for the cycle.
- `instr` in 16: instruction at the current `pc`; opcode is [15:12], compared against the `opcode.h` macros `B`, `CALL`, `RET`.
- `branch_taken` in 1: condition result from the flag register file for `instr`; meaningful only when the opcode is `B`.
- `pc` out 16: current program counter (registered).
- `sp` out log2(DEPTH)+1: number of valid return-stack entries, from 0 to DEPTH.
- `stack_empty` out 1: combinational, equals (`sp`==0).
- `stack_full` out 1: combinational, equals (`sp`==DEPTH).
- `stack_ovf` out 1: sticky; set by a CALL issued while the stack is full.
- `stack_udf` out 1: sticky; set by a RET issued while the stack is empty.

## Operation
- `seq` = `pc`+1, computed mod 2^16.
- `B` (branch):
  - instr[10:8] is the condition code, already evaluated externally; instr[11] is ignored.
  - `branch_taken`=1: `pc` ← `seq` + sext16(instr[7:0]).
  - `branch_taken`=0: `pc` ← `seq`.
- `CALL`:
  - Stack not full: push `seq` at index `sp`; `sp`←`sp`+1; `pc` ← `seq` + sext16(instr[11:0]).
  - Stack full: no push, `sp` unchanged, `stack_ovf`←1, `pc` ← `seq` (the call is suppressed).
- `RET`:
  - Stack not empty: `pc` ← entry[`sp`−1]; `sp`←`sp`−1.
  - Stack empty: `stack_udf`←1, `pc` ← `seq`.
- All other opcodes (ADD, SUB, NAND, XOR, INC, SRA, SRL, SLL, SW, LW, LHB, LLB, ...): `pc` ← `seq`. `branch_taken` is ignored.
- Address arithmetic is 16-bit two's complement and wraps silently. For example, 16'hFFFF+1 = 16'h0000, and 16'h0000 + sext(8'h80) + 1 = 16'hFF81.
- The return stack is a LIFO register array indexed by `sp`. Only one push or pop can occur per cycle, because a single instruction is handled per cycle, so no simultaneous push/pop case exists.
- `stack_ovf` and `stack_udf` are cleared only by `rst`. Once set they stay set, and the stack keeps operating normally afterwards.
- `stall`=1 overrides everything: `pc`, `sp`, stack contents and the sticky flags all hold. `instr` and `branch_taken` are ignored.
- `instr` containing X/Z bits in the opcode field is undefined use; this is not checked.

## Timing
- Reset values (`rst`=1, asynchronous, takes effect immediately, including mid-instruction):
  - `pc`=`RESET_PC`, `sp`=0, `stack_empty`=1, `stack_full`=0, `stack_ovf`=0, `stack_udf`=0.
  - Stack entry contents are don't-care after reset.
- Reset release: the first rising edge after `rst` falls performs a normal update from `RESET_PC`.
- Latency: one cycle. `instr` and `branch_taken` sampled at edge N determine `pc` after edge N.
- `branch_taken` comes combinationally from the flag file's current flags. Flags written by the previous instruction are therefore already visible, and no extra stall is needed.
- `sp`, `stack_empty`, `stack_full` and the sticky flags update on the same edge as `pc`.
- A CALL in cycle N followed by a RET in cycle N+1 must return to the pushed `seq`, i.e. the stack read in N+1 sees the write from N.

## Test plan
- Reset/sequential: assert `rst`, release, issue 3 ADDs → `pc` = 0,1,2,3 and `sp`=0. Assert `rst` mid-run → `pc`=0 immediately, without waiting for a clock edge.
- Branch: at `pc`=16'h0010, issue `B` with offset 8'hFE:
  - `branch_taken`=1 → `pc`=16'h000F.
  - Repeat with `branch_taken`=0 → `pc`=16'h0011.
  - An ADD with `branch_taken`=1 → `pc`+1.
- Call/return: at `pc`=16'h0020, CALL with offset 12'h010 → `pc`=16'h0031, `sp`=1. Then RET → `pc`=16'h0021, `sp`=0, `stack_empty`=1.
- Nesting and overflow (DEPTH=8):
  - 8 CALLs → `stack_full`=1.
  - A 9th CALL at `pc`=P → `pc`=P+1, `stack_ovf`=1, `sp`=8.
  - 8 RETs return the pushed addresses in reverse order.
- Underflow and wrap:
  - RET with `sp`=0 at `pc`=16'h0005 → `pc`=16'h0006, `stack_udf`=1, which stays 1 until `rst`.
  - At `pc`=16'hFFFF, an ADD → `pc`=16'h0000.
- Stall: hold `stall`=1 for 3 cycles while presenting CALL → `pc`, `sp` and the stack are unchanged. Release → the CALL executes once.

Source files
------------

// File: rtl/pc_unit_if.sv
// Fetch-side bundle for pc_unit: the instruction/condition inputs and the PC and
// return-stack status outputs.
interface pc_unit_if #(
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned SpW = $clog2(DEPTH) + 1;

   logic            stall;
   logic [15:0]     instr;
   logic            branch_taken;
   logic [15:0]     pc;
   logic [SpW-1:0]  sp;
   logic            stack_empty;
   logic            stack_full;
   logic            stack_ovf;
   logic            stack_udf;

   // Driver of instructions (fetch/decode side)
   modport master (
      output stall, instr, branch_taken,
      input  pc, sp, stack_empty, stack_full, stack_ovf, stack_udf
   );

   // The PC sequencer itself
   modport slave (
      input  stall, instr, branch_taken,
      output pc, sp, stack_empty, stack_full, stack_ovf, stack_udf
   );
endinterface

// File: rtl/pc_unit.sv
// Program counter and control-flow sequencer: sequential fetch, conditional
// branch, CALL/RET through a hardware return-address stack with sticky
// overflow/underflow flags.
module pc_unit #(
   parameter int unsigned DEPTH    = 8,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input logic      clk,
   input logic      rst,
   pc_unit_if.slave bus_io
);
   localparam int unsigned    AW  = $clog2(DEPTH);
   localparam int unsigned    SpW = AW + 1;
   localparam logic [SpW-1:0] DepthSp = SpW'(DEPTH);

   // Opcode values matching the B, CALL and RET definitions in opcode.h
   localparam logic [3:0] OpB    = 4'hC;
   localparam logic [3:0] OpCall = 4'hD;
   localparam logic [3:0] OpRet  = 4'hE;

   logic [15:0]    pc_q, pc_d;
   logic [SpW-1:0] sp_q, sp_d;
   logic           ovf_q, ovf_d;
   logic           udf_q, udf_d;
   logic [15:0]    stack_q [DEPTH];

   logic [15:0]    seq;
   logic [SpW-1:0] sp_dec;
   logic [AW-1:0]  push_idx;
   logic [AW-1:0]  pop_idx;
   logic           push_en;
   logic           is_empty;
   logic           is_full;

   assign seq      = pc_q + 16'd1;
   assign sp_dec   = sp_q - 1'b1;
   // Push only happens when sp < DEPTH, so the low bits index the slot exactly
   assign push_idx = sp_q[AW-1:0];
   assign pop_idx  = sp_dec[AW-1:0];
   assign is_empty = (sp_q == '0);
   assign is_full  = (sp_q == DepthSp);

   // Next-state: decode the current instruction into a new PC and stack action
   always_comb begin
      pc_d    = seq;
      sp_d    = sp_q;
      ovf_d   = ovf_q;
      udf_d   = udf_q;
      push_en = 1'b0;
      if (bus_io.stall) begin
         pc_d = pc_q;
      end else begin
         case (bus_io.instr[15:12])
            OpB: begin
               if (bus_io.branch_taken) begin
                  pc_d = seq + {{8{bus_io.instr[7]}}, bus_io.instr[7:0]};
               end
            end
            OpCall: begin
               if (is_full) begin
                  ovf_d = 1'b1;
               end else begin
                  push_en = 1'b1;
                  sp_d    = sp_q + 1'b1;
                  pc_d    = seq + {{4{bus_io.instr[11]}}, bus_io.instr[11:0]};
               end
            end
            OpRet: begin
               if (is_empty) begin
                  udf_d = 1'b1;
               end else begin
                  pc_d = stack_q[pop_idx];
                  sp_d = sp_dec;
               end
            end
            default: pc_d = seq;
         endcase
      end
   end

   // Control state with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q  <= RESET_PC;
         sp_q  <= '0;
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         pc_q  <= pc_d;
         sp_q  <= sp_d;
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   // Return-address storage; contents are don't-care after reset
   always_ff @(posedge clk) begin
      if (push_en) begin
         stack_q[push_idx] <= seq;
      end
   end

   assign bus_io.pc          = pc_q;
   assign bus_io.sp          = sp_q;
   assign bus_io.stack_empty = is_empty;
   assign bus_io.stack_full  = is_full;
   assign bus_io.stack_ovf   = ovf_q;
   assign bus_io.stack_udf   = udf_q;
endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus randomized
// instruction streams against a queue-based reference model.
module tb_pc_unit;
   localparam int unsigned DEPTH = 8;
   localparam logic [3:0]  OpAdd  = 4'h0;
   localparam logic [3:0]  OpB    = 4'hC;
   localparam logic [3:0]  OpCall = 4'hD;
   localparam logic [3:0]  OpRet  = 4'hE;

   logic clk;
   logic rst;

   pc_unit_if #(.DEPTH(DEPTH)) bus ();

   pc_unit #(
      .DEPTH    (DEPTH),
      .RESET_PC (16'h0000)
   ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state
   logic [15:0] pc_m;
   logic [15:0] stk_m[$];
   logic        ovf_m;
   logic        udf_m;

   int unsigned n_vec;
   int unsigned n_err;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pc"},    32'(bus.pc), 32'(pc_m));
      check({tag, ".sp"},    32'(bus.sp), 32'(stk_m.size()));
      check({tag, ".empty"}, 32'(bus.stack_empty), 32'(stk_m.size() == 0));
      check({tag, ".full"},  32'(bus.stack_full), 32'(stk_m.size() == DEPTH));
      check({tag, ".ovf"},   32'(bus.stack_ovf), 32'(ovf_m));
      check({tag, ".udf"},   32'(bus.stack_udf), 32'(udf_m));
   endtask

   // Assert reset between edges and check it takes effect without a clock
   task automatic do_reset();
      #2;
      rst = 1'b1;
      #1;
      pc_m  = 16'h0000;
      stk_m.delete();
      ovf_m = 1'b0;
      udf_m = 1'b0;
      check_all("reset");
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Apply one instruction for one edge, advance the model, compare #1 later
   task automatic step(input string tag, input logic [15:0] ins, input logic bt,
                       input logic st);
      logic [15:0] seq;
      bus.instr        = ins;
      bus.branch_taken = bt;
      bus.stall        = st;
      @(posedge clk);
      seq = pc_m + 16'd1;
      if (!st) begin
         case (ins[15:12])
            OpB:    pc_m = bt ? seq + {{8{ins[7]}}, ins[7:0]} : seq;
            OpCall: begin
               if (stk_m.size() < DEPTH) begin
                  stk_m.push_back(seq);
                  pc_m = seq + {{4{ins[11]}}, ins[11:0]};
               end else begin
                  ovf_m = 1'b1;
                  pc_m  = seq;
               end
            end
            OpRet: begin
               if (stk_m.size() > 0) begin
                  pc_m = stk_m.pop_back();
               end else begin
                  udf_m = 1'b1;
                  pc_m  = seq;
               end
            end
            default: pc_m = seq;
         endcase
      end
      #1;
      check_all(tag);
   endtask

   function automatic logic [15:0] mk(input logic [3:0] op, input logic [11:0] f);
      return {op, f};
   endfunction

   initial begin
      logic [15:0] p;
      logic [15:0] ins;
      int unsigned r;
      n_vec = 0;
      n_err = 0;
      rst   = 1'b0;
      bus.instr        = 16'h0000;
      bus.branch_taken = 1'b0;
      bus.stall        = 1'b0;
      @(negedge clk);

      // Reset and sequential fetch
      do_reset();
      for (int i = 0; i < 3; i++) step("seq", mk(OpAdd, 12'h123), 1'b0, 1'b0);
      check("seq_pc3", 32'(bus.pc), 32'h3);
      step("seq", mk(OpAdd, 12'h000), 1'b0, 1'b0);
      do_reset();
      check("rst_async_pc", 32'(bus.pc), 32'h0);

      // Branch: reach 0x10, then taken / not taken / ADD ignoring branch_taken
      step("br_go", mk(OpB, 12'h00F), 1'b1, 1'b0);
      check("br_at10", 32'(bus.pc), 32'h10);
      step("br_t", mk(OpB, 12'h7FE), 1'b1, 1'b0);
      check("br_taken", 32'(bus.pc), 32'h000F);
      step("br_go", mk(OpB, 12'h000), 1'b1, 1'b0);
      step("br_nt", mk(OpB, 12'h0FE), 1'b0, 1'b0);
      check("br_not_taken", 32'(bus.pc), 32'h0011);
      step("add_bt", mk(OpAdd, 12'h0FE), 1'b1, 1'b0);
      check("add_ignores_bt", 32'(bus.pc), 32'h0012);

      // Call/return from 0x20
      step("cr_go", mk(OpB, 12'h00D), 1'b1, 1'b0);
      check("cr_at20", 32'(bus.pc), 32'h20);
      step("call", mk(OpCall, 12'h010), 1'b0, 1'b0);
      check("call_pc", 32'(bus.pc), 32'h0031);
      check("call_sp", 32'(bus.sp), 32'h1);
      step("ret", mk(OpRet, 12'h000), 1'b0, 1'b0);
      check("ret_pc", 32'(bus.pc), 32'h0021);
      check("ret_empty", 32'(bus.stack_empty), 32'h1);

      // Nesting and overflow
      do_reset();
      for (int i = 0; i < DEPTH; i++) step("nest", mk(OpCall, 12'(i * 16 + 3)), 1'b0, 1'b0);
      check("nest_full", 32'(bus.stack_full), 32'h1);
      p = bus.pc;
      step("ovf", mk(OpCall, 12'h040), 1'b0, 1'b0);
      check("ovf_pc", 32'(bus.pc), 32'(p + 16'd1));
      check("ovf_flag", 32'(bus.stack_ovf), 32'h1);
      check("ovf_sp", 32'(bus.sp), 32'(DEPTH));
      for (int i = 0; i < DEPTH; i++) step("unwind", mk(OpRet, 12'h000), 1'b0, 1'b0);
      check("unwind_empty", 32'(bus.stack_empty), 32'h1);
      check("ovf_sticky", 32'(bus.stack_ovf), 32'h1);

      // Underflow and stickiness
      do_reset();
      step("udf_go", mk(OpB, 12'h004), 1'b1, 1'b0);
      step("udf", mk(OpRet, 12'h000), 1'b0, 1'b0);
      check("udf_pc", 32'(bus.pc), 32'h0006);
      check("udf_flag", 32'(bus.stack_udf), 32'h1);
      step("udf_call", mk(OpCall, 12'h001), 1'b0, 1'b0);
      step("udf_ret", mk(OpRet, 12'h000), 1'b0, 1'b0);
      check("udf_sticky", 32'(bus.stack_udf), 32'h1);

      // Address wrap
      do_reset();
      step("wrap_go", mk(OpB, 12'h0FE), 1'b1, 1'b0);
      check("wrap_ffff", 32'(bus.pc), 32'hFFFF);
      step("wrap", mk(OpAdd, 12'h000), 1'b0, 1'b0);
      check("wrap_0000", 32'(bus.pc), 32'h0000);
      do_reset();
      step("neg_off", mk(OpB, 12'h080), 1'b1, 1'b0);
      check("neg_off_pc", 32'(bus.pc), 32'hFF81);

      // Stall holds a presented CALL, which then executes exactly once
      step("pre", mk(OpCall, 12'h100), 1'b0, 1'b0);
      p = bus.pc;
      for (int i = 0; i < 3; i++) step("stall", mk(OpCall, 12'h020), 1'b0, 1'b1);
      check("stall_pc", 32'(bus.pc), 32'(p));
      check("stall_sp", 32'(bus.sp), 32'h1);
      step("unstall", mk(OpCall, 12'h020), 1'b0, 1'b0);
      check("unstall_sp", 32'(bus.sp), 32'h2);
      step("unstall_ret", mk(OpRet, 12'h000), 1'b0, 1'b0);
      check("unstall_ret_pc", 32'(bus.pc), 32'(p + 16'd1));

      // Randomized streams
      do_reset();
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 9);
         ins = 16'($urandom);
         if (r < 3)      ins[15:12] = OpCall;
         else if (r < 6) ins[15:12] = OpRet;
         else if (r < 8) ins[15:12] = OpB;
         step("rand", ins, 1'($urandom), ($urandom_range(0, 9) == 0));
         if ($urandom_range(0, 149) == 0) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
